// File: rtl/fifo_wr_sync_status_pkg.sv
// ---------------------------------------------------------------------------
// fifo_wr_sync_status_pkg
//   Shared definitions for the FIFO write-side read-pointer synchronizer and
//   status block: legal synchronizer depth bounds, the widest pointer the
//   Gray decoder handles, and the Gray-to-binary conversion function.
// ---------------------------------------------------------------------------
package fifo_wr_sync_status_pkg;

  // Legal synchronizer depth range.
  localparam int unsigned SYNC_STAGES_MIN = 2;
  localparam int unsigned SYNC_STAGES_MAX = 4;

  // Widest pointer the Gray decoder accepts; narrower pointers are
  // zero-extended, which leaves their low-order binary bits unchanged.
  localparam int unsigned PTR_MAX_W = 32;

  // Gray-to-binary: bin[i] = XOR of g[i..MSB].  Built as a log-depth
  // prefix XOR (shift-by-1, 2, 4, ...) instead of a serial bit chain.
  function automatic logic [PTR_MAX_W-1:0] gray2bin(input logic [PTR_MAX_W-1:0] g);
    logic [PTR_MAX_W-1:0] b;
    b = g;
    for (int unsigned s = 1; s < PTR_MAX_W; s = s << 1) begin
      b = b ^ (b >> s);
    end
    return b;
  endfunction

endpackage

// File: rtl/fifo_wr_sync_status_chain.sv
// ---------------------------------------------------------------------------
// ptr_sync_chain
//   Plain multi-flop synchronizer for a Gray-coded pointer.  Stages are
//   directly connected (no logic between flops).  Synchronous active-low
//   reset and a synchronous clear both zero every stage.
//
//   Ports
//     i_clk   : destination-domain clock
//     i_rst_n : synchronous active-low reset
//     i_clr   : synchronous clear (flush)
//     i_d     : asynchronous Gray pointer input
//     o_q     : synchronized pointer (last stage)
// ---------------------------------------------------------------------------
module ptr_sync_chain
  import fifo_wr_sync_status_pkg::*;
#(
  parameter int unsigned WIDTH  = 5,
  parameter int unsigned STAGES = 2
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_clr,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  if ((STAGES < SYNC_STAGES_MIN) || (STAGES > SYNC_STAGES_MAX)) begin : g_bad_stages
    $error("ptr_sync_chain: STAGES out of legal range");
  end

  logic [WIDTH-1:0] r_stage [STAGES];

  always_ff @(posedge i_clk) begin
    if (!i_rst_n || i_clr) begin
      for (int unsigned i = 0; i < STAGES; i++) begin
        r_stage[i] <= '0;
      end
    end else begin
      r_stage[0] <= i_d;
      for (int unsigned i = 1; i < STAGES; i++) begin
        r_stage[i] <= r_stage[i-1];
      end
    end
  end

  assign o_q = r_stage[STAGES-1];

endmodule

// File: rtl/fifo_wr_sync_status.sv
// ---------------------------------------------------------------------------
// fifo_wr_sync_status
//   Write-side half of an async FIFO: synchronizes the read pointer into the
//   write clock domain and derives registered fill level, full, almost-full
//   and a sticky overflow flag.  After reset or flush the synchronizer holds
//   stale zeros until it has refilled; during that window full/almost-full
//   are forced high so the writer is held off conservatively.
//
//   Ports
//     W_CLK         : write clock (only clock)
//     W_rst_n       : synchronous active-low reset (priority over flush)
//     flush         : synchronous clear of synchronizer and status
//     R_ptr_gray    : Gray read pointer from the read domain
//     W_ptr_bin     : local binary write pointer
//     Wq_rptr_gray  : synchronized Gray read pointer
//     Wq_rptr_bin   : binary form of Wq_rptr_gray (combinational)
//     W_level       : registered fill level
//     W_full        : registered full flag
//     W_almost_full : registered almost-full flag
//     sync_valid    : synchronizer holds post-reset/flush data
//     ovf_err       : sticky illegal-fill-level flag
// ---------------------------------------------------------------------------
module fifo_wr_sync_status
  import fifo_wr_sync_status_pkg::*;
#(
  parameter int unsigned ADDR_FIFO      = 4,
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned ALMOST_FULL_TH = 12
) (
  input  logic               W_CLK,
  input  logic               W_rst_n,
  input  logic               flush,
  input  logic [ADDR_FIFO:0] R_ptr_gray,
  input  logic [ADDR_FIFO:0] W_ptr_bin,
  output logic [ADDR_FIFO:0] Wq_rptr_gray,
  output logic [ADDR_FIFO:0] Wq_rptr_bin,
  output logic [ADDR_FIFO:0] W_level,
  output logic               W_full,
  output logic               W_almost_full,
  output logic               sync_valid,
  output logic               ovf_err
);

  localparam int unsigned PTR_W = ADDR_FIFO + 1;
  localparam int unsigned CNT_W = $clog2(SYNC_STAGES + 1);

  localparam logic [PTR_W-1:0] DEPTH     = PTR_W'(2 ** ADDR_FIFO);
  localparam logic [PTR_W-1:0] AF_TH     = PTR_W'(ALMOST_FULL_TH);
  localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(SYNC_STAGES);

  if ((SYNC_STAGES < SYNC_STAGES_MIN) || (SYNC_STAGES > SYNC_STAGES_MAX)) begin : g_bad_sync
    $error("fifo_wr_sync_status: SYNC_STAGES out of legal range");
  end
  if ((ALMOST_FULL_TH < 1) || (ALMOST_FULL_TH > 2 ** ADDR_FIFO)) begin : g_bad_th
    $error("fifo_wr_sync_status: ALMOST_FULL_TH out of legal range");
  end
  if (PTR_W > PTR_MAX_W) begin : g_bad_addr
    $error("fifo_wr_sync_status: ADDR_FIFO too wide for gray2bin");
  end

  logic [PTR_W-1:0] w_rptr_gray;
  logic [PTR_W-1:0] w_rptr_bin;
  logic [PTR_W-1:0] w_diff;
  logic             w_sync_valid;

  logic [CNT_W-1:0] r_fill_cnt;
  logic [PTR_W-1:0] r_level;
  logic             r_full;
  logic             r_almost_full;
  logic             r_ovf_err;

  ptr_sync_chain #(
    .WIDTH  (PTR_W),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .i_clk   (W_CLK),
    .i_rst_n (W_rst_n),
    .i_clr   (flush),
    .i_d     (R_ptr_gray),
    .o_q     (w_rptr_gray)
  );

  assign w_rptr_bin = PTR_W'(gray2bin(PTR_MAX_W'(w_rptr_gray)));

  // Modulo 2^PTR_W subtraction handles the MSB wrap without a special case.
  assign w_diff       = W_ptr_bin - w_rptr_bin;
  assign w_sync_valid = (r_fill_cnt == CNT_FULL);

  // Refill counter: counts edges since reset/flush, saturating at the
  // synchronizer depth.
  always_ff @(posedge W_CLK) begin
    if (!W_rst_n || flush) begin
      r_fill_cnt <= '0;
    end else if (!w_sync_valid) begin
      r_fill_cnt <= r_fill_cnt + CNT_W'(1);
    end
  end

  // Flags are forced by the sync_valid value present at the edge, so they
  // release one edge after sync_valid rises: that is the first edge whose
  // diff is computed from a fully refilled chain.
  always_ff @(posedge W_CLK) begin
    if (!W_rst_n || flush) begin
      r_level       <= '0;
      r_full        <= 1'b1;
      r_almost_full <= 1'b1;
      r_ovf_err     <= 1'b0;
    end else begin
      r_level       <= w_diff;
      r_full        <= (w_diff == DEPTH) || !w_sync_valid;
      r_almost_full <= (w_diff >= AF_TH) || !w_sync_valid;
      r_ovf_err     <= r_ovf_err || (w_diff > DEPTH);
    end
  end

  assign Wq_rptr_gray  = w_rptr_gray;
  assign Wq_rptr_bin   = w_rptr_bin;
  assign W_level       = r_level;
  assign W_full        = r_full;
  assign W_almost_full = r_almost_full;
  assign sync_valid    = w_sync_valid;
  assign ovf_err       = r_ovf_err;

endmodule

// File: tb/tb_fifo_wr_sync_status.sv
module tb_fifo_wr_sync_status;

  logic       clk;
  logic       rst_n;
  logic       flush;
  logic [4:0] rptr_gray;
  logic [4:0] wptr_bin;

  logic [4:0] a_qgray, a_qbin, a_level;
  logic       a_full, a_af, a_sv, a_ovf;
  logic [4:0] b_qgray, b_qbin, b_level;
  logic       b_full, b_af, b_sv, b_ovf;

  fifo_wr_sync_status #(
    .ADDR_FIFO      (4),
    .SYNC_STAGES    (2),
    .ALMOST_FULL_TH (12)
  ) dut_a (
    .W_CLK         (clk),
    .W_rst_n       (rst_n),
    .flush         (flush),
    .R_ptr_gray    (rptr_gray),
    .W_ptr_bin     (wptr_bin),
    .Wq_rptr_gray  (a_qgray),
    .Wq_rptr_bin   (a_qbin),
    .W_level       (a_level),
    .W_full        (a_full),
    .W_almost_full (a_af),
    .sync_valid    (a_sv),
    .ovf_err       (a_ovf)
  );

  fifo_wr_sync_status #(
    .ADDR_FIFO      (4),
    .SYNC_STAGES    (4),
    .ALMOST_FULL_TH (12)
  ) dut_b (
    .W_CLK         (clk),
    .W_rst_n       (rst_n),
    .flush         (flush),
    .R_ptr_gray    (rptr_gray),
    .W_ptr_bin     (wptr_bin),
    .Wq_rptr_gray  (b_qgray),
    .Wq_rptr_bin   (b_qbin),
    .W_level       (b_level),
    .W_full        (b_full),
    .W_almost_full (b_af),
    .sync_valid    (b_sv),
    .ovf_err       (b_ovf)
  );

  typedef enum logic [3:0] {
    S_LEVEL, S_FULL, S_AF, S_SV, S_OVF, S_QGRAY, S_QBIN,
    S_B_SV, S_B_QGRAY, S_B_QBIN, S_B_LEVEL
  } sig_e;

  typedef struct {
    int          cyc;
    sig_e        sig;
    logic [31:0] val;
    string       name;
  } exp_t;

  exp_t q_exp[$];
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] actual(input sig_e s);
    case (s)
      S_LEVEL:   return 32'(a_level);
      S_FULL:    return 32'(a_full);
      S_AF:      return 32'(a_af);
      S_SV:      return 32'(a_sv);
      S_OVF:     return 32'(a_ovf);
      S_QGRAY:   return 32'(a_qgray);
      S_QBIN:    return 32'(a_qbin);
      S_B_SV:    return 32'(b_sv);
      S_B_QGRAY: return 32'(b_qgray);
      S_B_QBIN:  return 32'(b_qbin);
      S_B_LEVEL: return 32'(b_level);
      default:   return 32'hdead_beef;
    endcase
  endfunction

  // Expected value for the state after 'dly' more rising edges.
  task automatic exp_at(input int dly, input sig_e s, input logic [31:0] v, input string nm);
    exp_t e;
    e.cyc  = cyc + dly;
    e.sig  = s;
    e.val  = v;
    e.name = nm;
    q_exp.push_back(e);
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Monitor: on every falling edge, compare all expectations due now.
  always @(negedge clk) begin
    for (int i = q_exp.size() - 1; i >= 0; i--) begin
      if (q_exp[i].cyc <= cyc) begin
        logic [31:0] act;
        act = actual(q_exp[i].sig);
        checks++;
        if (q_exp[i].cyc < cyc) begin
          failures++;
          $display("FAIL %s: expectation for cycle %0d missed (now %0d)",
                   q_exp[i].name, q_exp[i].cyc, cyc);
        end else if (act !== q_exp[i].val) begin
          failures++;
          $display("FAIL %s @cyc %0d: got %0d expected %0d",
                   q_exp[i].name, cyc, act, q_exp[i].val);
        end
        q_exp.delete(i);
      end
    end
  end

  initial begin
    rst_n     = 1'b0;
    flush     = 1'b0;
    rptr_gray = 5'd0;
    wptr_bin  = 5'd0;

    // Reset state
    step(2);
    exp_at(1, S_LEVEL, 0, "rst_level");
    exp_at(1, S_FULL,  1, "rst_full");
    exp_at(1, S_AF,    1, "rst_af");
    exp_at(1, S_SV,    0, "rst_sv");
    exp_at(1, S_OVF,   0, "rst_ovf");
    exp_at(1, S_QGRAY, 0, "rst_qgray");
    exp_at(1, S_QBIN,  0, "rst_qbin");
    step(1);

    // Release: sync_valid on 2nd edge, flags drop on 3rd
    rst_n = 1'b1;
    exp_at(1, S_SV,    0, "rel_sv_e1");
    exp_at(2, S_SV,    1, "rel_sv_e2");
    exp_at(2, S_FULL,  1, "rel_full_e2");
    exp_at(2, S_AF,    1, "rel_af_e2");
    exp_at(3, S_FULL,  0, "rel_full_e3");
    exp_at(3, S_AF,    0, "rel_af_e3");
    exp_at(3, S_LEVEL, 0, "rel_level_e3");
    exp_at(3, S_B_SV,  0, "b_rel_sv_e3");
    exp_at(4, S_B_SV,  1, "b_rel_sv_e4");
    step(4);

    // Full at level 16
    wptr_bin = 5'd16;
    exp_at(1, S_LEVEL, 16, "full_level");
    exp_at(1, S_FULL,  1,  "full_full");
    exp_at(1, S_AF,    1,  "full_af");
    exp_at(1, S_OVF,   0,  "full_ovf");
    step(1);

    // Read pointer step to gray(4)=6: 2 sync edges + 1 status edge
    rptr_gray = 5'd6;
    exp_at(1, S_QGRAY,   0,  "step_qgray_e1");
    exp_at(2, S_QGRAY,   6,  "step_qgray_e2");
    exp_at(2, S_QBIN,    4,  "step_qbin_e2");
    exp_at(2, S_LEVEL,   16, "step_level_e2");
    exp_at(3, S_LEVEL,   12, "step_level_e3");
    exp_at(3, S_FULL,    0,  "step_full_e3");
    exp_at(3, S_AF,      1,  "step_af_e3");
    exp_at(3, S_B_QGRAY, 0,  "b_step_qgray_e3");
    exp_at(4, S_B_QGRAY, 6,  "b_step_qgray_e4");
    exp_at(4, S_B_QBIN,  4,  "b_step_qbin_e4");
    step(4);

    // Just below almost-full threshold
    wptr_bin = 5'd15;
    exp_at(1, S_LEVEL, 11, "th_level");
    exp_at(1, S_AF,    0,  "th_af");
    exp_at(1, S_FULL,  0,  "th_full");
    step(1);

    // Move read pointer to 29 (gray 19) with a write pointer legal for both
    wptr_bin  = 5'd8;
    rptr_gray = 5'd19;
    exp_at(1, S_LEVEL, 4,  "mv_level_e1");
    exp_at(2, S_QGRAY, 19, "mv_qgray");
    exp_at(2, S_QBIN,  29, "mv_qbin");
    exp_at(3, S_LEVEL, 11, "mv_level_e3");
    step(3);

    // Wrap: wptr 3, rptr 29 -> level 6
    wptr_bin = 5'd3;
    exp_at(1, S_LEVEL, 6, "wrap_level");
    exp_at(1, S_OVF,   0, "wrap_ovf");
    exp_at(1, S_FULL,  0, "wrap_full");
    exp_at(1, S_AF,    0, "wrap_af");
    step(1);

    // Level 9, then flush held for two edges
    wptr_bin = 5'd6;
    exp_at(1, S_LEVEL, 9, "pre_flush_level");
    step(1);
    flush = 1'b1;
    exp_at(1, S_LEVEL, 0, "flush_level");
    exp_at(1, S_FULL,  1, "flush_full");
    exp_at(1, S_AF,    1, "flush_af");
    exp_at(1, S_SV,    0, "flush_sv");
    exp_at(1, S_QGRAY, 0, "flush_qgray");
    exp_at(1, S_QBIN,  0, "flush_qbin");
    exp_at(2, S_SV,    0, "flush_hold_sv");
    exp_at(2, S_LEVEL, 0, "flush_hold_level");
    exp_at(2, S_FULL,  1, "flush_hold_full");
    step(2);

    // Refill after flush
    flush = 1'b0;
    exp_at(1, S_SV,    0,  "refill_sv_e1");
    exp_at(1, S_LEVEL, 6,  "refill_level_e1");
    exp_at(1, S_AF,    1,  "refill_af_e1");
    exp_at(2, S_SV,    1,  "refill_sv_e2");
    exp_at(2, S_FULL,  1,  "refill_full_e2");
    exp_at(2, S_QGRAY, 19, "refill_qgray_e2");
    exp_at(3, S_FULL,  0,  "refill_full_e3");
    exp_at(3, S_AF,    0,  "refill_af_e3");
    exp_at(3, S_LEVEL, 9,  "refill_level_e3");
    step(3);

    // Return read pointer to 0 without exceeding depth
    rptr_gray = 5'd0;
    exp_at(2, S_QBIN,  0, "ret_qbin");
    exp_at(3, S_LEVEL, 6, "ret_level");
    step(3);

    // Illegal level 17 -> sticky ovf_err until flush
    wptr_bin = 5'd17;
    exp_at(1, S_OVF,   1,  "ovf_set");
    exp_at(1, S_LEVEL, 17, "ovf_level");
    exp_at(1, S_FULL,  0,  "ovf_full");
    exp_at(1, S_AF,    1,  "ovf_af");
    step(1);
    wptr_bin = 5'd5;
    exp_at(1, S_OVF,   1, "ovf_sticky_e1");
    exp_at(1, S_LEVEL, 5, "ovf_level_back");
    exp_at(2, S_OVF,   1, "ovf_sticky_e2");
    step(2);
    flush = 1'b1;
    exp_at(1, S_OVF, 0, "ovf_flush_clear");
    step(1);
    flush = 1'b0;
    step(3);

    // Reset takes priority over flush
    rst_n = 1'b0;
    flush = 1'b1;
    exp_at(1, S_LEVEL,   0, "rstpri_level");
    exp_at(1, S_SV,      0, "rstpri_sv");
    exp_at(1, S_FULL,    1, "rstpri_full");
    exp_at(1, S_B_LEVEL, 0, "b_rstpri_level");
    step(3);

    checks++;
    if (q_exp.size() != 0) begin
      failures++;
      $display("FAIL leftover: got %0d pending expectations, expected 0", q_exp.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fifo_wr_sync_status.md
FIFO_WR_SYNC_STATUS -- requirements
Module: fifo_wr_sync_status

Interface
REQ-001 SHALL have parameter ADDR_FIFO, default 4, FIFO address width; depth = 2^ADDR_FIFO; pointers are ADDR_FIFO+1 bits.
REQ-002 SHALL have parameter SYNC_STAGES, default 2, number of synchronizer flops; legal range 2..4.
REQ-003 SHALL have parameter ALMOST_FULL_TH, default 12, fill level at which W_almost_full asserts; legal range 1..2^ADDR_FIFO.
REQ-004 SHALL have port W_CLK, input, 1, write-side clock; the only clock.
REQ-005 SHALL have port W_rst_n, input, 1, reset; synchronous and active-low.
REQ-006 SHALL have port flush, input, 1, synchronous clear of the synchronizer and status.
REQ-007 SHALL have port R_ptr_gray, input, ADDR_FIFO+1, Gray-coded read pointer from the read domain.
REQ-008 SHALL have port W_ptr_bin, input, ADDR_FIFO+1, local binary write pointer.
REQ-009 SHALL have port Wq_rptr_gray, output, ADDR_FIFO+1, synchronized Gray read pointer (last stage).
REQ-010 SHALL have port Wq_rptr_bin, output, ADDR_FIFO+1, binary equivalent of Wq_rptr_gray.
REQ-011 SHALL have port W_level, output, ADDR_FIFO+1, registered fill level.
REQ-012 SHALL have port W_full, output, 1, registered full flag.
REQ-013 SHALL have port W_almost_full, output, 1, registered almost-full flag.
REQ-014 SHALL have port sync_valid, output, 1, high once the chain holds post-reset/flush data.
REQ-015 SHALL have port ovf_err, output, 1, sticky flag for an illegal fill level.

Function
REQ-016 Synchronizer SHALL be a SYNC_STAGES-deep register chain; R_ptr_gray present before edge k SHALL appear on Wq_rptr_gray after edge k+SYNC_STAGES-1.
REQ-017 Wq_rptr_bin SHALL be the combinational Gray-to-binary conversion of Wq_rptr_gray, with no extra latency.
REQ-018 diff SHALL be (W_ptr_bin - Wq_rptr_bin) modulo 2^(ADDR_FIFO+1); W_level SHALL register diff one edge later.
REQ-019 W_full SHALL register (diff == 2^ADDR_FIFO) OR (next sync_valid == 0).
REQ-020 W_almost_full SHALL register (diff >= ALMOST_FULL_TH) OR (next sync_valid == 0).
REQ-021 ovf_err SHALL set when diff > 2^ADDR_FIFO; it SHALL stay set until reset or flush.
REQ-022 A refill counter (0..SYNC_STAGES) SHALL clear on reset/flush and increment each edge until saturated; sync_valid SHALL be high only when the counter equals SYNC_STAGES.
REQ-023 While sync_valid is low, W_full and W_almost_full SHALL be forced to 1, which blocks writes conservatively.
REQ-024 Flush SHALL clear all chain stages, the level/flag registers, ovf_err, and the refill counter on the same edge; the reset value definitions apply.
REQ-025 If flush is held asserted, outputs SHALL stay at reset values; counting SHALL begin on the first edge with flush low.
REQ-026 Pointer wrap SHALL need no special case: modulo arithmetic gives the correct level across the MSB wrap.

Reset
REQ-027 When W_rst_n=0 at a W_CLK edge, every register SHALL clear: chain=0, W_level=0, W_full=1, W_almost_full=1, sync_valid=0, ovf_err=0; Wq_rptr_gray=Wq_rptr_bin=0.
REQ-028 Reset SHALL take priority over flush; there SHALL be no asynchronous reset path.

Structure
REQ-029 A shared package SHALL hold SYNC_STAGES legal bounds and the Gray-to-binary function.
REQ-030 The synchronizer chain SHALL be a sub-module named ptr_sync_chain, with parameters WIDTH and STAGES and a synchronous clear.
REQ-031 Chain flops SHALL carry no logic between stages.

Verification (ADDR_FIFO=4, ALMOST_FULL_TH=12)
REQ-032 Reset release, SYNC_STAGES=2: sync_valid rises on the 2nd edge after release; W_full/W_almost_full drop one edge later with W_level=0.
REQ-033 W_ptr_bin=16, R_ptr_gray=gray(0): W_level=16 and W_full=1; then R_ptr_gray=gray(4): after 2+1 edges, W_level=12, W_full=0, W_almost_full=1.
REQ-034 Wrap: W_ptr_bin=5'b00011, R_ptr_gray=gray(5'b11101): W_level=6 and ovf_err=0.
REQ-035 Flush mid-operation with W_level=9: the next edge clears the chain, W_level=0, flags=1, sync_valid=0; the refill repeats as in REQ-032.
REQ-036 Illegal W_ptr_bin=17, rptr=0: ovf_err=1 and stays set until flush.
REQ-037 SYNC_STAGES=4: a step on R_ptr_gray appears on Wq_rptr_gray exactly 4 edges later.
